// File: rtl/atm_cash_dispenser.sv
// Greedy note splitter and dispenser for four cassettes (10/20/50/100); proves feasibility on a
// shadow copy before driving the mechanism. Optional ack watchdog: `define DISPENSE_TIMEOUT_EN.
module atm_cash_dispenser #(
    parameter logic [7:0] INIT_COUNT = 8'd10,
    parameter int         MAX_NOTES  = 40
`ifdef DISPENSE_TIMEOUT_EN
    ,parameter int        ACK_TIMEOUT = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [11:0] req_amount,
    output logic        req_ready,
    input  logic        load_en,
    input  logic [1:0]  load_denom,
    input  logic [7:0]  load_count,
    output logic        note_valid,
    output logic [1:0]  note_denom,
    input  logic        note_ack,
    output logic        done,
    output logic        fail,
    output logic [1:0]  fail_code,
    output logic [11:0] dispensed_total,
    output logic [3:0]  cassette_low
);
    localparam int NW = $clog2(MAX_NOTES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PLAN, S_DISPENSE, S_DONE, S_FAIL} state_t;

    state_t          state_q, state_d;
    logic [11:0]     amount_q, amount_d;
    logic [11:0]     remaining_q, remaining_d;
    logic [NW-1:0]   notes_q, notes_d;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic [3:0][7:0] count_q, count_d;
    logic [11:0]     total_q, total_d;
    logic [1:0]      fail_code_q, fail_code_d;
    logic            gap_q, gap_d;
    logic [3:0]      low_q, low_d;
`ifdef DISPENSE_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
`endif

    logic [3:0][7:0] pick_src;
    logic            pick_found;
    logic [1:0]      pick_denom;
    logic [11:0]     pick_value;
    logic [11:0]     rem_after;

    function automatic logic [11:0] denom_value(input logic [1:0] d);
        case (d)
            2'd0:    return 12'd10;
            2'd1:    return 12'd20;
            2'd2:    return 12'd50;
            default: return 12'd100;
        endcase
    endfunction

    // PLAN picks from the shadow counts, DISPENSE from the real ones: same rule, same sequence.
    always_comb begin
        pick_src   = (state_q == S_PLAN) ? shadow_q : count_q;
        pick_found = 1'b0;
        pick_denom = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (pick_src[k] != 8'd0 && denom_value(2'(k)) <= remaining_q) begin
                pick_found = 1'b1;
                pick_denom = 2'(k);
            end
        end
        pick_value = denom_value(pick_denom);
        rem_after  = remaining_q - pick_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            amount_q    <= '0;
            remaining_q <= '0;
            notes_q     <= '0;
            shadow_q    <= '0;
            count_q     <= {4{INIT_COUNT}};
            total_q     <= '0;
            fail_code_q <= '0;
            gap_q       <= 1'b0;
            low_q       <= '0;
`ifdef DISPENSE_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            amount_q    <= amount_d;
            remaining_q <= remaining_d;
            notes_q     <= notes_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            total_q     <= total_d;
            fail_code_q <= fail_code_d;
            gap_q       <= gap_d;
            low_q       <= low_d;
`ifdef DISPENSE_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        amount_d    = amount_q;
        remaining_d = remaining_q;
        notes_d     = notes_q;
        shadow_d    = shadow_q;
        count_d     = count_q;
        total_d     = total_q;
        fail_code_d = fail_code_q;
        gap_d       = gap_q;
        for (int k = 0; k < 4; k++) low_d[k] = (count_q[k] < 8'd2);
`ifdef DISPENSE_TIMEOUT_EN
        tmo_d       = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    count_d[load_denom] = load_count;
                end else if (req_valid) begin
                    amount_d    = req_amount;
                    total_d     = '0;
                    fail_code_d = 2'd0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (amount_q == 12'd0 || (amount_q % 12'd10) != 12'd0) begin
                    fail_code_d = 2'd0;
                    state_d     = S_FAIL;
                end else begin
                    shadow_d    = count_q;
                    remaining_d = amount_q;
                    notes_d     = '0;
                    state_d     = S_PLAN;
                end
            end
            S_PLAN: begin
                if (!pick_found) begin
                    fail_code_d = 2'd2;
                    state_d     = S_FAIL;
                end else begin
                    shadow_d[pick_denom] = shadow_q[pick_denom] - 8'd1;
                    remaining_d          = rem_after;
                    notes_d              = notes_q + NW'(1);
                    if (rem_after == 12'd0) begin
                        remaining_d = amount_q;
                        gap_d       = 1'b0;
                        state_d     = S_DISPENSE;
                    end else if (notes_q + NW'(1) == NW'(MAX_NOTES)) begin
                        fail_code_d = 2'd1;
                        state_d     = S_FAIL;
                    end
                end
            end
            S_DISPENSE: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (!pick_found) begin
                    fail_code_d = 2'd2;
                    state_d     = S_FAIL;
                end else if (note_ack) begin
                    count_d[pick_denom] = count_q[pick_denom] - 8'd1;
                    total_d             = total_q + pick_value;
                    remaining_d         = rem_after;
                    if (rem_after == 12'd0) state_d = S_DONE;
                    else                    gap_d   = 1'b1;
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    fail_code_d = 2'd3;
                    state_d     = S_FAIL;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == S_IDLE) && !load_en;
        note_valid      = (state_q == S_DISPENSE) && !gap_q && pick_found;
        note_denom      = note_valid ? pick_denom : 2'd0;
        done            = (state_q == S_DONE);
        fail            = (state_q == S_FAIL);
        fail_code       = fail_code_q;
        dispensed_total = total_q;
        cassette_low    = low_q;
    end
endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Directed and randomized bench for atm_cash_dispenser against a greedy-split reference model.
module tb_atm_cash_dispenser;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [11:0] req_amount;
    logic        req_ready;
    logic        load_en;
    logic [1:0]  load_denom;
    logic [7:0]  load_count;
    logic        note_valid;
    logic [1:0]  note_denom;
    logic        note_ack;
    logic        done;
    logic        fail;
    logic [1:0]  fail_code;
    logic [11:0] dispensed_total;
    logic [3:0]  cassette_low;

    int n_checks = 0;
    int n_fail   = 0;

    int         cnt[4];
    int         val[4] = '{10, 20, 50, 100};
    logic [1:0] exp_q[$];

    atm_cash_dispenser dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .load_en(load_en), .load_denom(load_denom), .load_count(load_count),
        .note_valid(note_valid), .note_denom(note_denom), .note_ack(note_ack),
        .done(done), .fail(fail), .fail_code(fail_code),
        .dispensed_total(dispensed_total), .cassette_low(cassette_low)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: code 4 = feasible, otherwise the expected fail_code; exp_q holds the note order.
    task automatic plan_model(input int amount, output int code, output int picked);
        int sh[4];
        int rem;
        int d;
        exp_q.delete();
        picked = 0;
        if (amount == 0 || amount % 10 != 0) begin
            code = 0;
            return;
        end
        sh  = cnt;
        rem = amount;
        forever begin
            d = -1;
            for (int k = 3; k >= 0; k--)
                if (d < 0 && sh[k] > 0 && val[k] <= rem) d = k;
            if (d < 0) begin
                code = 2;
                return;
            end
            sh[d]--;
            rem -= val[d];
            picked++;
            exp_q.push_back(2'(d));
            if (rem == 0) begin
                code = 4;
                return;
            end
            if (picked == 40) begin
                code = 1;
                return;
            end
        end
    endtask

    task automatic do_load(input int d, input int c);
        @(negedge clk);
        load_en    = 1'b1;
        load_denom = 2'(d);
        load_count = 8'(c);
        req_valid  = 1'b1;
        req_amount = 12'd100;
        #1;
        chk("ready_during_load", req_ready, 0);
        @(negedge clk);
        load_en   = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("idle_after_load", req_ready, 1);
        cnt[d] = c;
    endtask

    task automatic check_low();
        logic [3:0] e;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) e[k] = (cnt[k] < 2);
        chk("cassette_low", cassette_low, e);
    endtask

    task automatic run_req(input int amount);
        int code;
        int picked;
        int cyc;
        int exp_lat;
        int total;
        int hold;
        logic [1:0] d;
        plan_model(amount, code, picked);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_amount = 12'(amount);
        @(negedge clk);
        req_valid  = 1'b0;
        req_amount = 12'($urandom);
        cyc = 1;
        while (!(fail || done || note_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        exp_lat = (code == 0) ? 2 : 2 + picked + ((code == 2) ? 1 : 0);
        chk("latency", cyc, exp_lat);
        if (code != 4) begin
            chk("fail_pulse", fail, 1);
            chk("fail_code", fail_code, code);
            chk("no_note_on_reject", note_valid, 0);
            chk("total_on_reject", dispensed_total, 0);
            @(negedge clk);
            chk("fail_one_cycle", fail, 0);
            chk("ready_after_fail", req_ready, 1);
            chk("fail_code_held", fail_code, code);
            return;
        end
        total = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            d = exp_q[i];
            chk("note_valid", note_valid, 1);
            chk("note_denom", note_denom, d);
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(negedge clk);
                chk("note_hold_valid", note_valid, 1);
                chk("note_hold_denom", note_denom, d);
            end
            note_ack = 1'b1;
            @(negedge clk);
            note_ack = 1'b0;
            cnt[d]--;
            total += val[d];
            chk("dispensed_total", dispensed_total, total);
            if (i == exp_q.size() - 1) begin
                chk("done_pulse", done, 1);
            end else begin
                chk("note_gap", note_valid, 0);
                note_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                note_ack = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", req_ready, 1);
        chk("fail_code_cleared", fail_code, 0);
        chk("total_held", dispensed_total, amount);
    endtask

    initial begin
        int code;
        int picked;
        int c;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_amount = '0;
        load_en    = 1'b0;
        load_denom = '0;
        load_count = '0;
        note_ack   = 1'b0;
        for (int k = 0; k < 4; k++) cnt[k] = 10;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_note_valid", note_valid, 0);
        chk("rst_note_denom", note_denom, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_total", dispensed_total, 0);
        chk("rst_low", cassette_low, 0);
        rst_n = 1'b1;

        run_req(180);
        check_low();
        run_req(185);
        run_req(0);

        do_load(0, 0);
        do_load(1, 3);
        do_load(2, 1);
        do_load(3, 0);
        check_low();
        run_req(60);
        do_load(0, 10);
        @(negedge clk);
        chk("fail_code_across_load", fail_code, 2);
        do_load(1, 10);
        do_load(2, 10);
        do_load(3, 200);
        run_req(4090);
        run_req(40);

`ifdef DISPENSE_TIMEOUT_EN
        do_load(3, 10);
        plan_model(200, code, picked);
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 12'd200;
        @(negedge clk);
        req_valid = 1'b0;
        c = 1;
        while (!note_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_first_note", note_denom, 3);
        note_ack = 1'b1;
        @(negedge clk);
        note_ack = 1'b0;
        cnt[3]--;
        @(negedge clk);
        chk("tmo_second_note", note_valid, 1);
        c = 0;
        while (!fail && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_latency", c, 16);
        chk("tmo_code", fail_code, 3);
        chk("tmo_total", dispensed_total, 100);
        chk("tmo_note_dropped", note_valid, 0);
        run_req(1000);
`endif

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0)
                do_load($urandom_range(0, 3), $urandom_range(0, 12));
            if ($urandom_range(0, 4) == 0) run_req($urandom_range(1, 4095));
            else                           run_req(10 * $urandom_range(1, 150));
            if (it % 8 == 0) check_low();
        end

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cnt[k] = 10;
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 12'd300;
        @(negedge clk);
        req_valid = 1'b0;
        c = 1;
        while (!note_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        note_ack = 1'b1;
        @(negedge clk);
        note_ack = 1'b0;
        @(negedge clk);
        chk("second_note_pending", note_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_note_valid", note_valid, 0);
        chk("midrst_total", dispensed_total, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_fail", fail, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1000);
        check_low();
        run_req(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
